// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid: upstream (in_*) and downstream (out_*) sides.
// The master side is the surrounding pipeline, and the slave side is the stage itself.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Parametrised MIPS pipeline stage with a 2-entry skid, registered ready and synchronous flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_accept;
  logic w_emit;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_emit   = r_out_valid & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_in_ready  <= (w_state_nxt != FULL);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, which prevents inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) w_state_nxt = ONE;
        ONE: begin
          if (w_emit && !w_accept)      w_state_nxt = EMPTY;
          else if (!w_emit && w_accept) w_state_nxt = FULL;
        end
        FULL:    if (w_emit) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // A flush discards the in-flight transfer, so it also suppresses the data loads.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!flush) begin
      unique case (r_state)
        EMPTY: w_load_main_in = w_accept;
        ONE: begin
          w_load_main_in = w_accept & w_emit;
          w_load_skid    = w_accept & !w_emit;
        end
        FULL:    w_load_main_skid = w_emit;
        default: ;
      endcase
    end
  end

  // NOTE: the payload registers are reset because downstream observes out_data=0 after reset; flush never clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= bus.in_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= bus.in_data;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign occupancy     = r_state;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_state != EMPTY) && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, stall/skid, flush and reset-over-flush.
// Counter checks follow PIPE_STAGE_PERF_EN (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_skid;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_skid_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  task automatic check_state(input string tag, input logic ov, input logic ir,
                             input logic [1:0] occ, input logic [DATA_W-1:0] od);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    check({tag, ".occupancy"}, 32'(occupancy),     32'(occ));
    check({tag, ".out_data"},  32'(bus.out_data),  32'(od));
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b1, 16'h0099, 1'b0);
    #1;

    // Reset held two cycles while upstream is presenting data.
    tick(); tick();
    check_state("reset", 1'b0, 1'b1, 2'd0, 16'h0000);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b1);
    tick();

    // Streaming 1..4 with out_ready high: one-cycle latency, occupancy pinned at 1.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1);
      tick();
      check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, DATA_W'(i));
    end
    drive(1'b0, 16'h0000, 1'b1);
    tick();
    check_state("stream_drain", 1'b0, 1'b1, 2'd0, 16'h0004);

    // Stall: A then B fill both entries; C is refused while full.
    drive(1'b1, 16'h000A, 1'b0);
    tick();
    check_state("stall_a", 1'b1, 1'b1, 2'd1, 16'h000A);
    drive(1'b1, 16'h000B, 1'b0);
    tick();
    check_state("stall_b", 1'b1, 1'b0, 2'd2, 16'h000A);
    drive(1'b1, 16'h000C, 1'b0);
    tick();
    check_state("stall_c", 1'b1, 1'b0, 2'd2, 16'h000A);
    drive(1'b0, 16'h000C, 1'b1);
    tick();
    check_state("release_a", 1'b1, 1'b1, 2'd1, 16'h000B);
    tick();
    check_state("release_b", 1'b0, 1'b1, 2'd0, 16'h000B);
    tick();
    check_state("no_c", 1'b0, 1'b1, 2'd0, 16'h000B);

    // Flush while full: the concurrent 0x55 push is dropped, payload register keeps 0x11.
    drive(1'b1, 16'h0011, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 1'b0);
    tick();
    check_state("full_pre_flush", 1'b1, 1'b0, 2'd2, 16'h0011);
    flush = 1'b1;
    drive(1'b1, 16'h0055, 1'b0);
    tick();
    flush = 1'b0;
    check_state("flush_full", 1'b0, 1'b1, 2'd0, 16'h0011);
`ifdef PIPE_STAGE_PERF_EN
    check("flush_cnt_one", 32'(flush_cnt), 32'd1);
`else
    check("flush_cnt_tied", 32'(flush_cnt), 32'd0);
`endif
    drive(1'b0, 16'h0000, 1'b1);
    tick();
    check_state("no_0x55", 1'b0, 1'b1, 2'd0, 16'h0011);

    // Reset together with flush at occupancy 1 yields pure reset values.
    drive(1'b1, 16'h0077, 1'b0);
    tick();
    check_state("occ1_pre_rst", 1'b1, 1'b1, 2'd1, 16'h0077);
    rst   = 1'b1;
    flush = 1'b1;
    drive(1'b1, 16'h0066, 1'b1);
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check_state("rst_flush", 1'b0, 1'b1, 2'd0, 16'h0000);
    check("rst_flush.flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_flush.stall_cnt", 32'(stall_cnt), 32'd0);

    // Long stall: 20 stalled cycles saturate a 4-bit counter at 15.
    drive(1'b1, 16'h0033, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check_state("long_stall", 1'b1, 1'b1, 2'd1, 16'h0033);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt_sat", 32'(stall_cnt), 32'd15);
`else
    check("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
